// File: rtl/mac_seq_if.sv
// Bundles the operand-memory, MAC and result ports of the dot-product sequencer.
// The master modport is the sequencer side; the slave modport is its environment.
`timescale 1ns/1ps

interface mac_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] a_base;
    logic [ADDR_WIDTH-1:0] b_base;

    logic                  a_rd_en;
    logic                  b_rd_en;
    logic [ADDR_WIDTH-1:0] a_rd_addr;
    logic [ADDR_WIDTH-1:0] b_rd_addr;
    logic [DATA_WIDTH-1:0] a_rd_data;
    logic [DATA_WIDTH-1:0] b_rd_data;

    logic                  mac_en;
    logic                  mac_valid_in;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [ACC_WIDTH-1:0]  mac_acc_in;
    logic [ACC_WIDTH-1:0]  mac_acc_out;
    logic                  mac_valid_out;

    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [ACC_WIDTH-1:0]  res_acc;

    modport master (
        input  start, len, a_base, b_base,
        output a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
        input  a_rd_data, b_rd_data,
        output mac_en, mac_valid_in, mac_a, mac_b, mac_acc_in,
        input  mac_acc_out, mac_valid_out,
        output busy, res_valid, res_data, res_acc,
        input  res_ready
    );

    modport slave (
        output start, len, a_base, b_base,
        input  a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
        output a_rd_data, b_rd_data,
        input  mac_en, mac_valid_in, mac_a, mac_b, mac_acc_in,
        output mac_acc_out, mac_valid_out,
        input  busy, res_valid, res_data, res_acc,
        output res_ready
    );
endinterface

// File: rtl/mac_seq.sv
// Dot-product sequencer: streams operand pairs through an external MAC one at a
// time, then requantizes the final accumulator to Q1.15 with rounding and saturation.
`timescale 1ns/1ps

module mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int ADDR_WIDTH = 10,
    parameter int FRAC_BITS  = 15
) (
    input  logic      clk,
    input  logic      rst,
    mac_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, ISSUE, WAIT, OUT} state_t;

    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = (ACC_WIDTH+1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX    = (ACC_WIDTH+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN    = ~SAT_MAX;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] len_reg;
    logic [ADDR_WIDTH-1:0] a_base_reg;
    logic [ADDR_WIDTH-1:0] b_base_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;
    logic [ACC_WIDTH-1:0]  acc_reg;

    logic                  rd_en_reg;
    logic [ADDR_WIDTH-1:0] a_rd_addr_reg;
    logic [ADDR_WIDTH-1:0] b_rd_addr_reg;
    logic                  mac_en_reg;
    logic [ACC_WIDTH-1:0]  mac_acc_in_reg;
    logic                  busy_reg;
    logic                  res_valid_reg;
    logic [DATA_WIDTH-1:0] res_data_reg;
    logic [ACC_WIDTH-1:0]  res_acc_reg;

    // Round half toward +inf via bias + arithmetic shift, one guard bit wide.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH:0] biased;
        logic signed [ACC_WIDTH:0] shifted;
        biased  = $signed({v[ACC_WIDTH-1], v}) + ROUND_BIAS;
        shifted = biased >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            requant = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            requant = SAT_MIN[DATA_WIDTH-1:0];
        else
            requant = shifted[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            a_base_reg     <= '0;
            b_base_reg     <= '0;
            idx_reg        <= '0;
            acc_reg        <= '0;
            rd_en_reg      <= 1'b0;
            a_rd_addr_reg  <= '0;
            b_rd_addr_reg  <= '0;
            mac_en_reg     <= 1'b0;
            mac_acc_in_reg <= '0;
            busy_reg       <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_acc_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        len_reg    <= bus.len;
                        a_base_reg <= bus.a_base;
                        b_base_reg <= bus.b_base;
                        idx_reg    <= '0;
                        acc_reg    <= '0;
                        busy_reg   <= 1'b1;
                        if (bus.len == '0) begin
                            state_reg     <= OUT;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= requant('0);
                            res_acc_reg   <= '0;
                        end else begin
                            state_reg     <= RD;
                            rd_en_reg     <= 1'b1;
                            a_rd_addr_reg <= bus.a_base;
                            b_rd_addr_reg <= bus.b_base;
                        end
                    end
                end
                RD: begin
                    rd_en_reg      <= 1'b0;
                    a_rd_addr_reg  <= '0;
                    b_rd_addr_reg  <= '0;
                    mac_en_reg     <= 1'b1;
                    mac_acc_in_reg <= acc_reg;
                    state_reg      <= ISSUE;
                end
                ISSUE: begin
                    mac_en_reg     <= 1'b0;
                    mac_acc_in_reg <= '0;
                    state_reg      <= WAIT;
                end
                WAIT: begin
                    if (bus.mac_valid_out) begin
                        acc_reg <= bus.mac_acc_out;
                        if (idx_reg == len_reg - ADDR_WIDTH'(1)) begin
                            state_reg     <= OUT;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= requant(bus.mac_acc_out);
                            res_acc_reg   <= bus.mac_acc_out;
                        end else begin
                            // Addresses wrap naturally in ADDR_WIDTH bits.
                            idx_reg       <= idx_reg + ADDR_WIDTH'(1);
                            rd_en_reg     <= 1'b1;
                            a_rd_addr_reg <= a_base_reg + idx_reg + ADDR_WIDTH'(1);
                            b_rd_addr_reg <= b_base_reg + idx_reg + ADDR_WIDTH'(1);
                            state_reg     <= RD;
                        end
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.a_rd_en      = rd_en_reg;
    assign bus.b_rd_en      = rd_en_reg;
    assign bus.a_rd_addr    = a_rd_addr_reg;
    assign bus.b_rd_addr    = b_rd_addr_reg;
    assign bus.mac_en       = mac_en_reg;
    assign bus.mac_valid_in = mac_en_reg;
    assign bus.mac_acc_in   = mac_acc_in_reg;
    // Read data lands in the ISSUE cycle, so operands pass straight through.
    assign bus.mac_a        = (state_reg == ISSUE) ? bus.a_rd_data : '0;
    assign bus.mac_b        = (state_reg == ISSUE) ? bus.b_rd_data : '0;
    assign bus.busy         = busy_reg;
    assign bus.res_valid    = res_valid_reg;
    assign bus.res_data     = res_data_reg;
    assign bus.res_acc      = res_acc_reg;
endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq with behavioural operand memories and a MAC of
// configurable latency; expected results are hand-computed dot products.
`timescale 1ns/1ps

module tb_mac_seq;
    localparam int DW  = 16;
    localparam int AW  = 40;
    localparam int ADW = 10;

    typedef struct {
        logic signed [DW-1:0] data;
        logic signed [AW-1:0] acc;
        int                   rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_seq_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

    mac_seq #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .FRAC_BITS(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories with one-cycle registered read
    logic signed [DW-1:0] mem_a [0:1023];
    logic signed [DW-1:0] mem_b [0:1023];
    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rd_data <= mem_a[bus.a_rd_addr];
        if (bus.b_rd_en) bus.b_rd_data <= mem_b[bus.b_rd_addr];
    end

    // MAC model: result appears lat cycles after mac_valid_in
    int                   lat = 1;
    int                   mcnt = 0;
    logic                 pend = 1'b0;
    logic                 vo_m = 1'b0;
    logic signed [AW-1:0] acc_m = '0;
    logic signed [AW-1:0] mres = '0;
    logic                 stray = 1'b0;
    logic signed [AW-1:0] stray_acc = '0;
    logic signed [AW-1:0] pa, pb, sum_m;
    assign pa    = {{(AW-DW){bus.mac_a[DW-1]}}, bus.mac_a};
    assign pb    = {{(AW-DW){bus.mac_b[DW-1]}}, bus.mac_b};
    assign sum_m = $signed(bus.mac_acc_in) + pa * pb;

    always @(posedge clk) begin
        vo_m <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (mcnt == 1) begin
                    vo_m  <= 1'b1;
                    acc_m <= mres;
                    pend  <= 1'b0;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
            if (bus.mac_valid_in) begin
                if (lat == 1) begin
                    vo_m  <= 1'b1;
                    acc_m <= sum_m;
                end else begin
                    pend <= 1'b1;
                    mcnt <= lat - 1;
                    mres <= sum_m;
                end
            end
        end
    end
    assign bus.mac_valid_out = vo_m | stray;
    assign bus.mac_acc_out   = stray ? stray_acc : acc_m;

    // Scoreboard monitor
    exp_t sb_q[$];
    exp_t cur;
    bit   have_cur   = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_rd    = 1'b0;
    int   n_rd  = 0;
    int   n_mvi = 0;
    int   a_log[$];
    int   b_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.a_rd_en) begin
                n_rd++;
                a_log.push_back(int'(bus.a_rd_addr));
            end
            if (bus.b_rd_en) b_log.push_back(int'(bus.b_rd_addr));
            if (bus.mac_valid_in) begin
                n_mvi++;
                chk("issue_one_cycle_after_read", prev_rd, 1);
            end
            if (bus.res_valid) begin
                if (!prev_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                        have_cur = 1'b0;
                    end else begin
                        cur = sb_q.pop_front();
                        have_cur = 1'b1;
                        chk("res_valid_cycle", cyc, cur.rise);
                    end
                end
                if (have_cur) begin
                    chk("res_data", $signed(bus.res_data), cur.data);
                    chk("res_acc", $signed(bus.res_acc), cur.acc);
                end
            end
        end
        prev_rd    = bus.a_rd_en;
        prev_valid = bus.res_valid;
    end

    task automatic issue(input int n, input int ab, input int bb,
                         input logic signed [DW-1:0] ed, input logic signed [AW-1:0] ea, input bit push);
        exp_t e;
        bus.start  = 1'b1;
        bus.len    = ADW'(n);
        bus.a_base = ADW'(ab);
        bus.b_base = ADW'(bb);
        e.data = ed;
        e.acc  = ea;
        e.rise = cyc + 1 + n * (2 + lat);
        if (push) sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic finish_cmd();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.res_valid && bus.res_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("result_handshake", ok, 1);
        @(negedge clk);
        chk("idle_after_accept", bus.busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_strobes"}, {bus.busy, bus.res_valid, bus.a_rd_en, bus.b_rd_en, bus.mac_en, bus.mac_valid_in}, 0);
        chk({tag, "_addrs"}, {bus.a_rd_addr, bus.b_rd_addr}, 0);
        chk({tag, "_mac_ops"}, {bus.mac_a, bus.mac_b}, 0);
        chk({tag, "_mac_acc_in"}, bus.mac_acc_in, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_res_acc"}, bus.res_acc, 0);
    endtask

    initial begin
        int rd0, m0, qa0, qb0, k;
        bit ok;
        int exp_addr [4] = '{1022, 1023, 0, 1};

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[0] = 16384;  mem_a[1] = -8192;  mem_a[2] = 3277;   mem_a[3] = 16384;
        mem_b[100] = 8192; mem_b[101] = 16384; mem_b[102] = -3277; mem_b[103] = -16384;
        mem_a[10] = 32767; mem_a[11] = 32767; mem_b[10] = 32767; mem_b[11] = 32767;
        mem_a[20] = -32768; mem_a[21] = -32768; mem_b[30] = 32767; mem_b[31] = 32767;
        mem_a[1022] = 1; mem_a[1023] = 2;
        mem_b[500] = 10; mem_b[501] = 20; mem_b[502] = 30; mem_b[503] = 40;
        mem_a[40] = 100; mem_b[40] = -200;
        mem_a[50] = 1; mem_a[51] = 1; mem_a[52] = 1;
        mem_b[50] = 1; mem_b[51] = 1; mem_b[52] = 1;
        mem_a[60] = 3; mem_b[60] = 4;

        bus.start = 1'b0; bus.len = '0; bus.a_base = '0; bus.b_base = '0;
        bus.res_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(4, 0, 100, -8520, -279174185, 1);
        finish_cmd();
        $display("txn basic len=4: res_acc=%0d res_data=%0d", $signed(bus.res_acc), $signed(bus.res_data));

        issue(2, 10, 10, 32767, 2147352578, 1);
        finish_cmd();
        $display("txn pos-sat len=2: res_acc=%0d res_data=%0d", $signed(bus.res_acc), $signed(bus.res_data));

        issue(2, 20, 30, -32768, -2147418112, 1);
        finish_cmd();
        $display("txn neg-sat len=2: res_acc=%0d res_data=%0d", $signed(bus.res_acc), $signed(bus.res_data));

        rd0 = n_rd; m0 = n_mvi;
        issue(0, 7, 7, 0, 0, 1);
        finish_cmd();
        chk("len0_no_reads", n_rd - rd0, 0);
        chk("len0_no_issues", n_mvi - m0, 0);
        $display("txn len=0: reads=%0d issues=%0d", n_rd - rd0, n_mvi - m0);

        rd0 = n_rd; m0 = n_mvi; qa0 = a_log.size(); qb0 = b_log.size();
        issue(4, 1022, 500, 5, 163890, 1);
        finish_cmd();
        chk("wrap_read_count", n_rd - rd0, 4);
        chk("wrap_issue_count", n_mvi - m0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_a_addr", (a_log.size() > qa0 + i) ? a_log[qa0 + i] : -1, exp_addr[i]);
            chk("wrap_b_addr", (b_log.size() > qb0 + i) ? b_log[qb0 + i] : -1, 500 + i);
        end
        $display("txn wrap a_base=1022 len=4: reads=%0d issues=%0d", n_rd - rd0, n_mvi - m0);

        bus.res_ready = 1'b0;
        issue(1, 40, 40, -1, -20000, 1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("stall_result_arrives", ok, 1);
        rd0 = n_rd;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.start = 1'b1;
                bus.len   = ADW'(2);
            end else begin
                bus.start = 1'b0;
            end
            chk("stall_res_valid_held", bus.res_valid, 1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("stall_idle_after_ready", bus.busy, 0);
        chk("stall_valid_dropped", bus.res_valid, 0);
        repeat (3) @(negedge clk);
        chk("stall_start_ignored_busy", bus.busy, 0);
        chk("stall_start_ignored_reads", n_rd - rd0, 0);
        $display("txn backpressure len=1: res_data held, stray start ignored");

        lat = 4;
        issue(3, 50, 50, 0, 0, 0);
        ok = 1'b0; k = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.mac_valid_in) begin
                k++;
                if (k == 2) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        chk("reset_reach_pair2", ok, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b1;
        stray_acc = 12345;
        chk_zero("midrun_reset");
        @(negedge clk);
        stray = 1'b0;
        chk_zero("after_stray");
        repeat (2) @(negedge clk);
        chk("reset_stays_idle", bus.busy, 0);
        $display("txn reset in WAIT: outputs cleared, stray mac_valid_out ignored");

        lat = 1;
        issue(1, 60, 60, 0, 12, 1);
        finish_cmd();
        $display("txn post-reset len=1: res_acc=%0d res_data=%0d", $signed(bus.res_acc), $signed(bus.res_data));

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mac_seq.md
# mac_seq

Dot-product sequencer that drives a `mac_unit` as its initiator. On a start command it reads `len` operand pairs from two single-port operand memories and issues them one at a time to the MAC, feeding the running accumulator back through `acc_in`. It then requantizes the final accumulator to Q1.15 with rounding and saturation, and presents the result on a valid/ready output. It sits between the conv-layer controller and the MAC datapath.

## Interface
- `DATA_WIDTH`, 16, operand and result width (signed Q1.15)
- `ACC_WIDTH`, 40, accumulator width
- `ADDR_WIDTH`, 10, operand memory address width
- `FRAC_BITS`, 15, fractional bits removed at requantization
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  command strobe; sampled only in IDLE
- `len`  in  ADDR_WIDTH  number of pairs (0..2^ADDR_WIDTH-1); captured with `start`
- `a_base`, `b_base`  in  ADDR_WIDTH  base addresses; captured with `start`
- `a_rd_en`, `b_rd_en`  out  1  memory read enables
- `a_rd_addr`, `b_rd_addr`  out  ADDR_WIDTH  read addresses (base + index, wraps mod 2^ADDR_WIDTH)
- `a_rd_data`, `b_rd_data`  in  DATA_WIDTH  read data, valid 1 cycle after `*_rd_en`
- `mac_en`, `mac_valid_in`  out  1  MAC issue strobes
- `mac_a`, `mac_b`  out  DATA_WIDTH  MAC operands
- `mac_acc_in`  out  ACC_WIDTH  running accumulator
- `mac_acc_out`  in  ACC_WIDTH  MAC result
- `mac_valid_out`  in  1  MAC result valid
- `busy`  out  1  high in every state except IDLE
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accept
- `res_data`  out  DATA_WIDTH  requantized result
- `res_acc`  out  ACC_WIDTH  raw final accumulator

## Operation
- States: IDLE, RD, ISSUE, WAIT, OUT.
- IDLE: on `start`, capture `len`/bases, set idx=0 and acc=0. Go to OUT if `len`==0, else to RD.
- RD: assert `a_rd_en`/`b_rd_en` with address base+idx. Go to ISSUE.
- ISSUE: assert `mac_en` and `mac_valid_in`. Drive `mac_a`=`a_rd_data`, `mac_b`=`b_rd_data`, `mac_acc_in`=acc. Go to WAIT.
- WAIT: hold until `mac_valid_out`, then acc <= `mac_acc_out`. If idx==len-1, go to OUT; else idx++ and go to RD.
- OUT: `res_valid`=1, and `res_data`/`res_acc` are held stable. On `res_ready`, go to IDLE.
- Only one pair is in flight at a time, because of the accumulator dependency.
- `mac_valid_out` outside WAIT is ignored.
- `start` outside IDLE is ignored, with no queuing.
- Outside their states, `mac_a`, `mac_b` and `mac_acc_in` are 0, and all strobes are 0.
- Requantization:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, computed in ACC_WIDTH+1 bits with an arithmetic shift (round half toward +inf).
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register the result into `res_data` on entry to OUT.
- `rst` in any state: go to IDLE and clear idx, acc and all captured fields. Any in-flight MAC result is discarded.

## Timing
- Reset values: every output is 0 (`busy`, `res_valid`, `res_data`, `res_acc`, rd enables/addresses, MAC strobes/operands).
- `start` sampled at edge 0: RD is the state in cycle 1, and `busy` goes high in cycle 1.
- Per pair: 2 + L cycles, where L is the MAC latency from `mac_valid_in` to `mac_valid_out` (L ≥ 1; L = 1 for the unpipelined MAC).
- `res_valid` first goes high in cycle 1 + len·(2+L); for len=0 this is cycle 1.
- With `res_ready` high on the first OUT cycle, IDLE follows in the next cycle. A new `start` can be accepted in that IDLE cycle.
- Backpressure: OUT holds indefinitely while `res_ready`=0.

## Test plan
- Pairs (16384, 8192), (−8192, 16384), (3277, −3277), (16384, −16384), len=4, L=1 -> `res_acc`=−279174185 and `res_data`=−8520. `res_valid` rises in cycle 13.
- Pairs (32767, 32767)×2 -> `res_acc`=2147352578 and `res_data`=32767 (positive saturation). Pairs (−32768, 32767)×2 -> `res_acc`=−2147418112 and `res_data`=−32768 (negative saturation).
- len=0 -> `res_valid`=1 in cycle 1 with `res_data`=0 and `res_acc`=0, and no `*_rd_en` or `mac_valid_in` pulses.
- `res_ready` held low for 5 cycles in OUT, with `start` pulsed meanwhile -> `res_valid` and `res_data` stay stable and `start` is ignored. IDLE follows the cycle after `res_ready`=1.
- `a_base`=1022, len=4 -> read addresses are 1022, 1023, 0, 1 (wrap). `mac_valid_in` is asserted exactly 4 times, each one cycle after a read.
- `rst` asserted during WAIT of pair 2, with a stray `mac_valid_out` the cycle after -> all outputs are 0 and the block stays in IDLE. A new len=1 command (3, 4) then gives `res_acc`=12 and `res_data`=0.
